level_accumulator: RTL
======================

// Module: level_accumulator
// PURPOSE
//  Holds one internal quantity (energy, stress or pleasure) as a saturating counter.
//  It is driven by the *_inc/*_dec enables that the behaviour controllers produce.
//  It returns the 2-bit *_indicator level, with hysteresis, that those controllers consume.
//  One instance per quantity; closes the controller feedback loop.
// PARAMETERS
//  WIDTH        8    level counter width (unsigned)
//  PRESCALE     4    clocks per update tick (>=1)
//  RESET_LEVEL  128  level value after reset
//  TH1          64   threshold for indicator 01
//  TH2          128  threshold for indicator 10
//  TH3          192  threshold for indicator 11
//  HYST         8    falling hysteresis (HYST < TH1, TH1<TH2<TH3 <= 2^WIDTH-1)
//  LEAK_DIV     8    ticks per leak step (only with LEVEL_LEAK_EN)
// PORTS
//  clk          in   1      system clock
//  rst          in   1      asynchronous active-high reset
//  inc          in   1      increment enable (level-sampled on tick)
//  dec          in   1      decrement enable (level-sampled on tick)
//  level        out  WIDTH  current counter value
//  indicator    out  2      quantised level 00..11, hysteretic
//  at_max       out  1      level == 2^WIDTH-1
//  at_min       out  1      level == 0
//  ind_changed  out  1      one-cycle pulse when indicator changes
// BEHAVIOUR
//  Interface: one clock clk; reset rst is asynchronous and active-high.
//  Reset values:
//   - level = RESET_LEVEL; prescaler = 0; leak counter = 0; ind_changed = 0.
//   - indicator = band of RESET_LEVEL, no hysteresis (defaults: 10).
//   - at_max / at_min derived from RESET_LEVEL.
//  Prescaler:
//   - free-running 0..PRESCALE-1; tick = (count == PRESCALE-1).
//   - PRESCALE=1 gives tick every cycle.
//  Level update, on the edge where tick=1 only:
//   - inc & !dec -> +1, saturating at 2^WIDTH-1.
//   - dec & !inc -> -1, saturating at 0.
//   - inc & dec, or neither -> hold (except leak, see CONFIGURATION).
//   - inc/dec are ignored on non-tick cycles.
//  Indicator (registered; 1-cycle latency after level changes; at most one step per cycle):
//   - rise from k to k+1 when level >= TH[k+1].
//   - fall from k to k-1 when level < TH[k] - HYST.
//   - otherwise hold.
//   - ind_changed = 1 for exactly the cycle in which indicator takes its new value.
//  at_max / at_min: combinational from level.
//  Reset asserted mid-operation: immediate return to reset values; prescaler phase restarts at 0.
// CONFIGURATION
//  LEVEL_LEAK_EN defined:
//   - leak counter counts ticks on which neither or both of inc/dec are set.
//   - every LEAK_DIV such ticks, level steps 1 toward RESET_LEVEL (none if equal).
//   - any tick with exactly one of inc/dec set clears the leak counter.
//  LEVEL_LEAK_EN undefined: no leak logic; idle ticks always hold level.
// STRUCTURE
//  Shared package mood_pkg:
//   - indicator codes IND_LOW=2'b00, IND_MID_LO=2'b01, IND_MID_HI=2'b10, IND_HIGH=2'b11.
//   - function band_of(level, TH1, TH2, TH3) (non-hysteretic band, used for reset).
//  Sub-module tick_prescaler(PRESCALE): clk, rst -> tick. Reused by other timed blocks.
// TESTING (defaults)
//  1 Reset:
//    - rst pulse -> level=128, indicator=10, at_max=0, at_min=0, ind_changed=0.
//  2 Ramp up:
//    - inc=1, dec=0 from reset -> level +1 every 4 clk; level=192 after the 64th tick.
//    - indicator=11 one cycle later, ind_changed one-cycle pulse.
//  3 Hysteresis:
//    - from level 192 / ind 11, hold dec -> ind stays 11 at level 184.
//    - ind goes to 10 one cycle after level reaches 183.
//  4 Saturation:
//    - inc held 2000 clk -> level=255, at_max=1, level stays 255.
//    - then dec 1 tick -> 254.
//  5 Conflict / off-tick:
//    - inc=dec=1 for 40 clk -> level unchanged.
//    - inc pulsed only on non-tick cycles -> level unchanged.
//  6 Leak (LEVEL_LEAK_EN):
//    - level=140, inputs idle -> level=139 after 8 ticks (32 clk).
//    - level settles at 128 and holds.
//    - without the macro, level stays 140.

Source files
------------

// File: rtl/mood_pkg.sv
// Shared definitions for the mood/level blocks: indicator codes and the
// non-hysteretic band function used to seed the indicator at reset.
package mood_pkg;

    localparam logic [1:0] IND_LOW    = 2'b00;
    localparam logic [1:0] IND_MID_LO = 2'b01;
    localparam logic [1:0] IND_MID_HI = 2'b10;
    localparam logic [1:0] IND_HIGH   = 2'b11;

    // Plain threshold quantisation, no hysteresis.
    function automatic logic [1:0] band_of(input int unsigned lvl,
                                           input int unsigned th1,
                                           input int unsigned th2,
                                           input int unsigned th3);
        if (lvl >= th3)      return IND_HIGH;
        else if (lvl >= th2) return IND_MID_HI;
        else if (lvl >= th1) return IND_MID_LO;
        else                 return IND_LOW;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler: counts 0..PRESCALE-1 and raises tick on the last
// count. PRESCALE=1 gives a tick every cycle.
module tick_prescaler #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;

    // Wrap the phase counter on the last count; reset restarts the phase at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                cnt_q <= '0;
        else if (cnt_q == LAST) cnt_q <= '0;
        else                    cnt_q <= cnt_q + CW'(1);
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/level_accumulator.sv
// Saturating level counter for one internal quantity (energy, stress or
// pleasure). inc/dec are sampled only on prescaler ticks; the 2-bit indicator
// follows the level with one cycle of latency and falling hysteresis.
// Optional feature macro: LEVEL_LEAK_EN -- idle ticks slowly pull the level
// back toward RESET_LEVEL.
module level_accumulator
    import mood_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned PRESCALE    = 4,
    parameter int unsigned RESET_LEVEL = 128,
    parameter int unsigned TH1         = 64,
    parameter int unsigned TH2         = 128,
    parameter int unsigned TH3         = 192,
    parameter int unsigned HYST        = 8,
    parameter int unsigned LEAK_DIV    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] level,
    output logic [1:0]       indicator,
    output logic             at_max,
    output logic             at_min,
    output logic             ind_changed
);

    localparam logic [WIDTH-1:0] LVL_MAX = '1;
    localparam logic [WIDTH-1:0] RST_LVL = WIDTH'(RESET_LEVEL);
    localparam logic [WIDTH-1:0] RISE1   = WIDTH'(TH1);
    localparam logic [WIDTH-1:0] RISE2   = WIDTH'(TH2);
    localparam logic [WIDTH-1:0] RISE3   = WIDTH'(TH3);
    // Falling edges sit HYST below the matching rising threshold.
    localparam logic [WIDTH-1:0] FALL1   = WIDTH'(TH1 - HYST);
    localparam logic [WIDTH-1:0] FALL2   = WIDTH'(TH2 - HYST);
    localparam logic [WIDTH-1:0] FALL3   = WIDTH'(TH3 - HYST);
    localparam logic [1:0]       RST_IND = band_of(RESET_LEVEL, TH1, TH2, TH3);

    logic             tick;
    logic             step_up;
    logic             step_dn;
    logic [WIDTH-1:0] level_q;
    logic [WIDTH-1:0] level_d;
    logic [1:0]       ind_q;
    logic [1:0]       ind_d;
    logic             ind_chg_q;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_presc (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // A tick with exactly one request set is an active tick.
    assign step_up = tick & inc & ~dec;
    assign step_dn = tick & dec & ~inc;

`ifdef LEVEL_LEAK_EN
    localparam int unsigned LCW = (LEAK_DIV > 1) ? $clog2(LEAK_DIV) : 1;
    localparam logic [LCW-1:0] LEAK_LAST = LCW'(LEAK_DIV - 1);

    logic           idle_tick;
    logic           leak_step;
    logic [LCW-1:0] leak_cnt_q;

    assign idle_tick = tick & ~(inc ^ dec);
    assign leak_step = idle_tick && (leak_cnt_q == LEAK_LAST);

    // Count idle ticks; any active tick restarts the leak interval.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   leak_cnt_q <= '0;
        else if (step_up | step_dn) leak_cnt_q <= '0;
        else if (leak_step)        leak_cnt_q <= '0;
        else if (idle_tick)        leak_cnt_q <= leak_cnt_q + LCW'(1);
    end
`else
    logic unused_leak_cfg;
    assign unused_leak_cfg = (LEAK_DIV == 0);
`endif

    // Next level: saturating step on active ticks, optional leak on idle ones.
    always_comb begin
        level_d = level_q;
        if (step_up) begin
            if (level_q != LVL_MAX) level_d = level_q + WIDTH'(1);
        end else if (step_dn) begin
            if (level_q != '0) level_d = level_q - WIDTH'(1);
        end
`ifdef LEVEL_LEAK_EN
        else if (leak_step) begin
            if (level_q > RST_LVL)      level_d = level_q - WIDTH'(1);
            else if (level_q < RST_LVL) level_d = level_q + WIDTH'(1);
        end
`endif
    end

    // Level register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) level_q <= RST_LVL;
        else     level_q <= level_d;
    end

    // Next indicator: at most one band step per cycle, hysteresis on falls.
    always_comb begin
        ind_d = ind_q;
        case (ind_q)
            IND_LOW: begin
                if (level_q >= RISE1) ind_d = IND_MID_LO;
            end
            IND_MID_LO: begin
                if (level_q >= RISE2)     ind_d = IND_MID_HI;
                else if (level_q < FALL1) ind_d = IND_LOW;
            end
            IND_MID_HI: begin
                if (level_q >= RISE3)     ind_d = IND_HIGH;
                else if (level_q < FALL2) ind_d = IND_MID_LO;
            end
            default: begin
                if (level_q < FALL3) ind_d = IND_MID_HI;
            end
        endcase
    end

    // Indicator register and its change pulse, aligned with the new value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ind_q     <= RST_IND;
            ind_chg_q <= 1'b0;
        end else begin
            ind_q     <= ind_d;
            ind_chg_q <= (ind_d != ind_q);
        end
    end

    assign level       = level_q;
    assign indicator   = ind_q;
    assign ind_changed = ind_chg_q;
    assign at_max      = (level_q == LVL_MAX);
    assign at_min      = (level_q == '0);

endmodule
